// File: rtl/shift_sequencer_if.sv
// Handshake/bus bundle for the shift sequencer: request fields driven by the
// master, status and registered result/flags driven by the slave.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic             la;
  logic             lr;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             c;
  logic             v;
  logic             n;
  logic             z;

  modport master (
    output start, la, lr, a, amt,
    input  busy, done, y, c, v, n, z
  );

  modport slave (
    input  start, la, lr, a, amt,
    output busy, done, y, c, v, n, z
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one single-bit shift per clock (arithmetic right,
// logical right or left) followed by a one-cycle done pulse with the
// registered result and C/V/N/Z flags.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic [AMT_W-1:0] r_cnt;
  logic             r_la;
  logic             r_lr;

  logic [WIDTH-1:0] r_y;
  logic             r_c;
  logic             r_n;
  logic             r_z;

  logic [WIDTH-1:0] w_step_val;
  logic             w_step_carry;
  logic             w_accept;
  logic             w_accept_zero;
  logic             w_last_step;

  assign w_accept      = (r_state == S_IDLE) && bus.start;
  assign w_accept_zero = w_accept && (bus.amt == '0);
  // The counter holds the number of steps still to do, so the step taken
  // while it reads 1 is the final one.
  assign w_last_step   = (r_state == S_SHIFT) && (r_cnt == AMT_W'(1));

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == AMT_W'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // One single-bit step of the working register; arithmetic right replicates
  // the sign bit, logical right and left fill with zero.
  always_comb begin
    w_step_val   = r_work;
    w_step_carry = r_carry;
    if (r_lr) begin
      w_step_val   = {r_la & r_work[WIDTH-1], r_work[WIDTH-1:1]};
      w_step_carry = r_work[0];
    end else begin
      w_step_val   = {r_work[WIDTH-2:0], 1'b0};
      w_step_carry = r_work[WIDTH-1];
    end
  end

  // Working registers: captured on accept, stepped once per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_la    <= 1'b0;
      r_lr    <= 1'b0;
    end else if (w_accept) begin
      r_work  <= bus.a;
      r_carry <= 1'b0;
      r_cnt   <= bus.amt;
      r_la    <= bus.la;
      r_lr    <= bus.lr;
    end else if (r_state == S_SHIFT) begin
      r_work  <= w_step_val;
      r_carry <= w_step_carry;
      r_cnt   <= r_cnt - AMT_W'(1);
    end
  end

  // Result/flag registers: only updated on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
      r_c <= 1'b0;
      r_n <= 1'b0;
      r_z <= 1'b0;
    end else if (w_accept_zero) begin
      r_y <= bus.a;
      r_c <= 1'b0;
      r_n <= bus.a[WIDTH-1];
      r_z <= (bus.a == '0);
    end else if (w_last_step) begin
      r_y <= w_step_val;
      r_c <= w_step_carry;
      r_n <= w_step_val[WIDTH-1];
      r_z <= (w_step_val == '0);
    end
  end

  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = (r_state == S_DONE);
  assign bus.y    = r_y;
  assign bus.c    = r_c;
  assign bus.v    = 1'b0;
  assign bus.n    = r_n;
  assign bus.z    = r_z;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver pushes hand-computed
// expectations on each accepted start, the monitor pops them on every done.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       v;
    logic       n;
    logic       z;
    logic [3:0] busy;
  } exp_t;

  exp_t       exp_q[$];
  int         total    = 0;
  int         bad      = 0;
  int         busy_run = 0;
  logic [7:0] last_y   = 8'h00;
  logic       rst_q    = 1'b0;
  logic       end_req  = 1'b0;

  // Reset as seen by the DUT on the most recent edge
  always @(posedge clk) rst_q <= rst;

  // Monitor: checks reset state, result hold during SHIFT and every done
  always @(negedge clk) begin
    exp_t e;
    exp_t act;
    if (rst_q) begin
      total++;
      if ({bus.busy, bus.done, bus.y, bus.c, bus.v, bus.n, bus.z} != 13'd0) begin
        bad++;
        $display("FAIL reset_state got busy=%b done=%b y=%h c=%b v=%b n=%b z=%b want all 0",
                 bus.busy, bus.done, bus.y, bus.c, bus.v, bus.n, bus.z);
      end
      $display("reset: busy=%b done=%b y=%h", bus.busy, bus.done, bus.y);
      exp_q.delete();
      busy_run = 0;
    end else if (bus.done === 1'b1) begin
      act = '{y: bus.y, c: bus.c, v: bus.v, n: bus.n, z: bus.z, busy: busy_run[3:0]};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done got y=%h c=%b busy_cycles=%0d want no done",
                 bus.y, bus.c, busy_run);
      end else begin
        e = exp_q.pop_front();
        if (act != e) begin
          bad++;
          $display("FAIL result got y=%h c=%b v=%b n=%b z=%b busy=%0d want y=%h c=%b v=%b n=%b z=%b busy=%0d",
                   act.y, act.c, act.v, act.n, act.z, act.busy,
                   e.y, e.c, e.v, e.n, e.z, e.busy);
        end
        $display("done: y=%h c=%b v=%b n=%b z=%b busy_cycles=%0d", act.y, act.c, act.v, act.n, act.z, busy_run);
      end
      busy_run = 0;
    end else if (bus.busy === 1'b1) begin
      total++;
      if (bus.y !== last_y) begin
        bad++;
        $display("FAIL hold_in_shift got y=%h want %h", bus.y, last_y);
      end
      busy_run++;
    end else begin
      busy_run = 0;
    end
    last_y = bus.y;
    if (end_req) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL missing_done got pending=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Drive a request (time: just after an edge); push the expectation once the
  // accepting edge has passed, then scramble the inputs to show they are ignored.
  task automatic start_op(input logic [7:0] a, input logic [2:0] amt, input logic la,
                          input logic lr, input logic [7:0] ey, input logic ec,
                          input logic en, input logic ez);
    bus.start = 1'b1;
    bus.a     = a;
    bus.amt   = amt;
    bus.la    = la;
    bus.lr    = lr;
    @(posedge clk);
    exp_q.push_back('{y: ey, c: ec, v: 1'b0, n: en, z: ez, busy: {1'b0, amt}});
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.amt   = ~amt;
    bus.la    = ~la;
    bus.lr    = ~lr;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Back-to-back op at the earliest legal restart (edge Ek+2)
  task automatic run_op(input logic [7:0] a, input logic [2:0] amt, input logic la,
                        input logic lr, input logic [7:0] ey, input logic ec,
                        input logic en, input logic ez);
    start_op(a, amt, la, lr, ey, ec, en, ez);
    wait_cycles(int'(amt) + 1);
  endtask

  // Directed stimulus
  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.amt   = 3'd2;
    bus.la    = 1'b0;
    bus.lr    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // accepted on the first edge after reset release
    run_op(8'h96, 3'd3, 1'b1, 1'b1, 8'hF2, 1'b1, 1'b1, 1'b0);
    run_op(8'h96, 3'd3, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 3'd7, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    run_op(8'h80, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op(8'h01, 3'd7, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op(8'h3C, 3'd2, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0);
    run_op(8'h5A, 3'd0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    // start during SHIFT is ignored; original completes at E5
    start_op(8'h96, 3'd5, 1'b1, 1'b1, 8'hFC, 1'b1, 1'b1, 1'b0);
    wait_cycles(1);
    bus.start = 1'b1;
    bus.a     = 8'h00;
    bus.amt   = 3'd0;
    bus.lr    = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_cycles(4);

    // reset at E3 aborts with no done; new start at E4 is accepted
    start_op(8'h96, 3'd5, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    wait_cycles(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(8'h01, 3'd7, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    wait_cycles(2);
    end_req = 1'b1;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want summary");
    $fatal(1, "watchdog");
  end

endmodule
